// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: rotates among enabled 13-bit sources,
// converts the owner's value to BCD with a serial double-dabble engine and drives blanked digits.
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 50000,
   parameter int ROT_CYC  = 100000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] val0,
   input  logic [12:0] val1,
   input  logic [12:0] val2,
   input  logic [12:0] val3,
   input  logic [3:0]  src_en,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic [1:0]  cur_src,
   output logic        busy
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(ROT_CYC);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [RW-1:0] ROT_MAX  = RW'(ROT_CYC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} conv_state_t;

   conv_state_t   state_r, state_s;
   logic [3:0]    cnt_r;
   logic [12:0]   bin_r;
   logic [15:0]   bcd_r, bcd_adj_s;
   logic [28:0]   shifted_s;
   logic [1:0]    tag_r, cur_src_r, next_src_s, idx_r;
   logic [RW-1:0] rot_cnt_r;
   logic [SW-1:0] scan_cnt_r;
   logic [15:0]   digits_r;
   logic [3:0]    mask_r, mask_s, an_r, digit_s;
   logic [7:0]    seg_r;
   logic [12:0]   sel_val_s;
   logic          valid_r, busy_r, rot_tick_s, owner_off_s, latch_s, lit_s;

   function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] en);
      logic [1:0] res;
      logic [1:0] cand;
      res = cur;
      for (int i = 3; i >= 1; i--) begin
         cand = cur + 2'(i);
         if (en[cand]) res = cand;
      end
      return res;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Converter next-state and shared combinational decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (src_en != 4'd0) state_s = LOAD;
            else                state_s = IDLE;
         end
         LOAD:  state_s = SHIFT;
         SHIFT: begin
            if (cnt_r == 4'd12) state_s = DONE;
            else                state_s = SHIFT;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
      case (cur_src_r)
         2'd0:    sel_val_s = val0;
         2'd1:    sel_val_s = val1;
         2'd2:    sel_val_s = val2;
         2'd3:    sel_val_s = val3;
         default: sel_val_s = 13'd0;
      endcase
      case (idx_r)
         2'd0:    digit_s = digits_r[3:0];
         2'd1:    digit_s = digits_r[7:4];
         2'd2:    digit_s = digits_r[11:8];
         2'd3:    digit_s = digits_r[15:12];
         default: digit_s = 4'd0;
      endcase
      bcd_adj_s   = {add3(bcd_r[15:12]), add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
      shifted_s   = {bcd_adj_s, bin_r} << 1;
      mask_s[3]   = (bcd_r[15:12] != 4'd0);
      mask_s[2]   = (bcd_r[11:8] != 4'd0) | mask_s[3];
      mask_s[1]   = (bcd_r[7:4] != 4'd0) | mask_s[2];
      mask_s[0]   = 1'b1;
      next_src_s  = next_enabled(cur_src_r, src_en);
      rot_tick_s  = (rot_cnt_r == ROT_MAX);
      owner_off_s = (src_en != 4'd0) && !src_en[cur_src_r];
      // A result only survives if its source still owns the display and is enabled
      latch_s     = (state_r == DONE) && (tag_r == cur_src_r) && src_en[cur_src_r];
      lit_s       = valid_r & mask_r[idx_r];
   end

   // Converter state and double-dabble datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         cnt_r   <= 4'd0;
         bin_r   <= 13'd0;
         bcd_r   <= 16'd0;
         tag_r   <= 2'd0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         case (state_r)
            LOAD: begin
               bin_r <= sel_val_s;
               tag_r <= cur_src_r;
               bcd_r <= 16'd0;
               cnt_r <= 4'd0;
            end
            SHIFT: begin
               bcd_r <= shifted_s[28:13];
               bin_r <= shifted_s[12:0];
               cnt_r <= cnt_r + 4'd1;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Display ownership, rotation and latched digits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_src_r <= 2'd0;
         rot_cnt_r <= '0;
         valid_r   <= 1'b0;
         digits_r  <= 16'd0;
         mask_r    <= 4'd0;
      end else begin
         rot_cnt_r <= rot_tick_s ? '0 : rot_cnt_r + RW'(1);
         if (owner_off_s) begin
            cur_src_r <= next_src_s;
            rot_cnt_r <= '0;
            valid_r   <= 1'b0;
         end else if (src_en == 4'd0) begin
            valid_r <= 1'b0;
         end else if (rot_tick_s) begin
            cur_src_r <= next_src_s;
         end
         if (latch_s) begin
            valid_r  <= 1'b1;
            digits_r <= bcd_r;
            mask_r   <= mask_s;
         end
      end
   end

   // Digit scan and registered anode/segment drive
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_r <= '0;
         idx_r      <= 2'd0;
         an_r       <= 4'hF;
         seg_r      <= 8'hFF;
      end else begin
         if (scan_cnt_r == SCAN_MAX) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 2'd1;
         end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
         end
         an_r  <= lit_s ? ~(4'b0001 << idx_r) : 4'hF;
         seg_r <= lit_s ? seg_code(digit_s) : 8'hFF;
      end
   end

   assign an      = an_r;
   assign seg     = seg_r;
   assign cur_src = cur_src_r;
   assign busy    = busy_r;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a decimal-arithmetic display model compared every cycle,
// plus directed scenarios with hand-computed digit/segment expectations.
module tb_seg_scan_ctrl;
   localparam int SD = 4;
   localparam int RC = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] val0 = 13'd0, val1 = 13'd0, val2 = 13'd0, val3 = 13'd0;
   logic [3:0]  src_en = 4'd0;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [1:0]  cur_src;
   logic        busy;

   int n_tests = 0, n_fails = 0, cmp_tests = 0, cmp_fails = 0;

   seg_scan_ctrl #(.SCAN_DIV(SD), .ROT_CYC(RC)) dut (
      .clk(clk), .rst_n(rst_n), .val0(val0), .val1(val1), .val2(val2), .val3(val3),
      .src_en(src_en), .an(an), .seg(seg), .cur_src(cur_src), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] segcode(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic int pow10(input int i);
      case (i)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic int nexten(input int c, input logic [3:0] en);
      for (int k = 1; k <= 3; k++) if (en[(c + k) % 4]) return (c + k) % 4;
      return c;
   endfunction

   function automatic int valsel(input int c);
      case (c)
         0: return int'(val0);
         1: return int'(val1);
         2: return int'(val2);
         default: return int'(val3);
      endcase
   endfunction

   // Model: phase 0 idle, 1 load, 2..14 shifting, 15 done; digits come from plain decimal arithmetic
   int ph = 0, tag = 0, snap = 0, cur = 0, rot = 0, scan = 0, idx = 0, mval = 0, p = 1;
   bit mvalid = 0, mok = 0, mlatch = 0, mtick = 0;
   logic [3:0] man = 4'hF;
   logic [7:0] mseg = 8'hFF;
   logic mbusy = 1'b0;

   always begin
      @(posedge clk);
      if (!rst_n) begin
         ph = 0; tag = 0; snap = 0; cur = 0; rot = 0; scan = 0; idx = 0; mval = 0;
         mvalid = 0; man = 4'hF; mseg = 8'hFF; mbusy = 1'b0; mok = 1;
      end else begin
         p = pow10(idx);
         man = 4'hF;
         mseg = 8'hFF;
         if (mvalid && (idx == 0 || mval >= p)) begin
            man[idx] = 1'b0;
            mseg = segcode((mval / p) % 10);
         end
         if (scan == SD - 1) begin scan = 0; idx = (idx + 1) % 4; end
         else scan = scan + 1;
         mlatch = (ph == 15) && (tag == cur) && src_en[cur];
         if (mlatch) mval = snap;
         if (ph == 0) ph = (src_en != 4'd0) ? 1 : 0;
         else if (ph == 1) begin snap = valsel(cur); tag = cur; ph = 2; end
         else if (ph == 15) ph = 0;
         else ph = ph + 1;
         mtick = (rot == RC - 1);
         rot = mtick ? 0 : rot + 1;
         if (src_en != 4'd0 && !src_en[cur]) begin cur = nexten(cur, src_en); rot = 0; mvalid = 0; end
         else if (src_en == 4'd0) mvalid = 0;
         else if (mtick) cur = nexten(cur, src_en);
         if (mlatch) mvalid = 1;
         mbusy = (ph != 0);
      end
      @(negedge clk);
      if (mok) begin
         cmp_tests += 4;
         if (an !== man) begin cmp_fails++; $display("FAIL model_an t=%0t got %h want %h", $time, an, man); end
         if (seg !== mseg) begin cmp_fails++; $display("FAIL model_seg t=%0t got %h want %h", $time, seg, mseg); end
         if (cur_src !== 2'(cur)) begin cmp_fails++; $display("FAIL model_cur t=%0t got %0d want %0d", $time, cur_src, cur); end
         if (busy !== mbusy) begin cmp_fails++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, mbusy); end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Watch a full scan; esegs = {thousands, hundreds, tens, ones}
   task automatic sweep(input string nm, input logic [3:0] emask, input logic [31:0] esegs);
      logic [3:0] seen = 4'd0;
      logic [7:0] gs [4];
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (an[k] == 1'b0) begin seen[k] = 1'b1; gs[k] = seg; end
      end
      @(posedge clk); #1;
      chk({nm, "_mask"}, int'(seen), int'(emask));
      for (int k = 0; k < 4; k++) if (emask[k] && seen[k]) chk($sformatf("%s_seg%0d", nm, k), int'(gs[k]), int'(esegs[k*8 +: 8]));
   endtask

   task automatic wait_cur(input string nm, input logic [1:0] want);
      int n = 0;
      while (cur_src != want && n < 200) begin tick(1); n++; end
      chk(nm, int'(cur_src), int'(want));
   endtask

   task automatic wait_busy(input string nm, input logic want);
      int n = 0;
      while (busy != want && n < 40) begin tick(1); n++; end
      chk(nm, int'(busy), int'(want));
   endtask

   initial begin
      int bad;
      tick(2);
      chk("rst_an", int'(an), 'hF);
      chk("rst_seg", int'(seg), 'hFF);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cur", int'(cur_src), 0);
      rst_n = 1'b1;

      src_en = 4'b0001; val0 = 13'd1234;
      tick(34); sweep("s1_1234", 4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99});
      val0 = 13'd7;    tick(34); sweep("s2_7", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hF8});
      val0 = 13'd0;    tick(34); sweep("s2_0", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
      val0 = 13'd8191; tick(34); sweep("s2_8191", 4'hF, {8'h80, 8'hF9, 8'h90, 8'hF9});

      src_en = 4'b0101; val0 = 13'd5; val2 = 13'd42;
      wait_cur("s3_to2", 2'd2);
      tick(40); sweep("s3_42", 4'b0011, {8'hFF, 8'hFF, 8'h99, 8'hA4});
      wait_cur("s3_to0", 2'd0);
      tick(40); sweep("s3_5", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'h92});

      rst_n = 1'b0; tick(1);
      rst_n = 1'b1; src_en = 4'b0011; val0 = 13'd1234; val1 = 13'd56;
      tick(34);
      wait_busy("s4_busy_lo", 1'b0);
      wait_busy("s4_busy_hi", 1'b1);
      tick(3); src_en = 4'b0010;
      tick(1); chk("s4_cur", int'(cur_src), 1);
      tick(1); chk("s4_blank_an", int'(an), 'hF);
      tick(32); sweep("s4_56", 4'b0011, {8'hFF, 8'hFF, 8'h92, 8'h82});

      src_en = 4'b0000;
      tick(16); chk("s5_busy", int'(busy), 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (an != 4'hF || seg != 8'hFF || busy) bad++;
         tick(1);
      end
      chk("s5_idle_cycles_bad", bad, 0);

      src_en = 4'b0001; val0 = 13'd1234;
      wait_busy("s6_busy_hi", 1'b1);
      tick(4); rst_n = 1'b0;
      tick(1);
      chk("s6_an", int'(an), 'hF);
      chk("s6_seg", int'(seg), 'hFF);
      chk("s6_busy", int'(busy), 0);
      chk("s6_cur", int'(cur_src), 0);
      rst_n = 1'b1;
      tick(33); sweep("s6_1234", 4'hF, {8'hF9, 8'hA4, 8'hB0, 8'h99});

      n_tests = n_tests + cmp_tests;
      n_fails = n_fails + cmp_fails;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end
endmodule
